// File: rtl/ofdm_cp_remover.sv
`default_nettype none
// ============================================================================
// Module   : ofdm_cp_remover
// Brief    : Strips the cyclic prefix from each OFDM symbol of a packet-framed
//            sample stream and emits one tlast-terminated symbol per FFT frame.
// Revision : 1.0 - initial release
// ============================================================================
module ofdm_cp_remover #(
    parameter int CNT_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [CNT_W-1:0]  fft_size,
    input  logic [CNT_W-1:0]  cp_size,
    input  logic [DATA_W-1:0] i_tdata,
    input  logic              i_tlast,
    input  logic              i_tvalid,
    output logic              i_tready,
    output logic [DATA_W-1:0] o_tdata,
    output logic              o_tlast,
    output logic              o_tvalid,
    input  logic              o_tready,
    output logic [CNT_W-1:0]  sym_count,
    output logic              trunc_err
);

    localparam logic [0:0] c_st_cp   = 1'b0;
    localparam logic [0:0] c_st_data = 1'b1;

    logic [0:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_fft_l;
    logic [CNT_W-1:0]  r_cp_l;
    logic              r_start;
    logic [DATA_W-1:0] r_tdata;
    logic              r_tlast;
    logic              r_tvalid;
    logic [CNT_W-1:0]  r_sym_count;
    logic              r_trunc;

    logic [CNT_W-1:0]  w_fft_in;
    logic [CNT_W-1:0]  w_fft;
    logic [CNT_W-1:0]  w_cp;
    logic [0:0]        w_state;
    logic [CNT_W-1:0]  w_cnt;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_cp_end;
    logic              w_fft_end;

    logic [0:0]        w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_start_nxt;
    logic              w_sym_inc;
    logic              w_trunc;
    logic              w_load;
    logic              w_last_nxt;

    // The symbol-start cycle works from the live size inputs so that it can
    // also accept a sample; this keeps symbol boundaries free of bubbles.
    assign w_fft_in = (fft_size == '0) ? CNT_W'(1) : fft_size;
    assign w_fft    = r_start ? w_fft_in : r_fft_l;
    assign w_cp     = r_start ? cp_size  : r_cp_l;
    assign w_state  = r_start ? ((cp_size == '0) ? c_st_data : c_st_cp) : r_state;
    assign w_cnt    = r_start ? '0 : r_cnt;

    assign w_in_ready = ~clear & ((w_state == c_st_cp) | ~r_tvalid | o_tready);
    assign w_accept   = i_tvalid & w_in_ready;
    assign w_cp_end   = (w_cnt == (w_cp - 1'b1));
    assign w_fft_end  = (w_cnt == (w_fft - 1'b1));

    always_comb begin
        w_state_nxt = w_state;
        w_cnt_nxt   = w_cnt;
        w_start_nxt = 1'b0;
        w_sym_inc   = 1'b0;
        w_trunc     = 1'b0;
        w_load      = 1'b0;
        w_last_nxt  = 1'b0;
        if (clear) begin
            w_state_nxt = c_st_cp;
            w_cnt_nxt   = '0;
            w_start_nxt = 1'b1;
        end else if (w_accept) begin
            case (w_state)
                c_st_cp: begin
                    // A packet ending inside the prefix yields no output at all.
                    if (i_tlast) begin
                        w_trunc     = 1'b1;
                        w_start_nxt = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = c_st_cp;
                    end else if (w_cp_end) begin
                        w_state_nxt = c_st_data;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt + 1'b1;
                    end
                end
                default: begin
                    w_load = 1'b1;
                    if (w_fft_end) begin
                        w_last_nxt  = 1'b1;
                        w_sym_inc   = 1'b1;
                        w_start_nxt = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = c_st_cp;
                    end else if (i_tlast) begin
                        w_last_nxt  = 1'b1;
                        w_trunc     = 1'b1;
                        w_start_nxt = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = c_st_cp;
                    end else begin
                        w_cnt_nxt = w_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_cp;
            r_cnt   <= '0;
            r_fft_l <= CNT_W'(1);
            r_cp_l  <= '0;
            r_start <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_start <= w_start_nxt;
            if (r_start && !clear) begin
                r_fft_l <= w_fft_in;
                r_cp_l  <= cp_size;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tdata     <= '0;
            r_tlast     <= 1'b0;
            r_tvalid    <= 1'b0;
            r_sym_count <= '0;
            r_trunc     <= 1'b0;
        end else begin
            r_trunc <= w_trunc;
            if (w_sym_inc) begin
                r_sym_count <= r_sym_count + 1'b1;
            end
            if (clear) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
            end else if (w_load) begin
                r_tdata  <= i_tdata;
                r_tlast  <= w_last_nxt;
                r_tvalid <= 1'b1;
            end else if (o_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign i_tready  = w_in_ready;
    assign o_tdata   = r_tdata;
    assign o_tlast   = r_tlast;
    assign o_tvalid  = r_tvalid;
    assign sym_count = r_sym_count;
    assign trunc_err = r_trunc;

endmodule
`default_nettype wire

// File: tb/tb_ofdm_cp_remover.sv
`default_nettype none
// ============================================================================
// Module   : tb_ofdm_cp_remover
// Brief    : Directed self-checking bench for ofdm_cp_remover.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ofdm_cp_remover;

    localparam int CNT_W  = 16;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              clear;
    logic [CNT_W-1:0]  fft_size;
    logic [CNT_W-1:0]  cp_size;
    logic [DATA_W-1:0] i_tdata;
    logic              i_tlast;
    logic              i_tvalid;
    logic              i_tready;
    logic [DATA_W-1:0] o_tdata;
    logic              o_tlast;
    logic              o_tvalid;
    logic              o_tready = 1'b1;
    logic [CNT_W-1:0]  sym_count;
    logic              trunc_err;

    ofdm_cp_remover #(.CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .fft_size(fft_size), .cp_size(cp_size),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .sym_count(sym_count), .trunc_err(trunc_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int trunc_cnt = 0;
    int stall_viol = 0;
    int cp_stalls = 0;
    int acc_cyc = -1;
    int out_cyc = -1;
    bit bp_mode = 1'b0;
    logic [DATA_W:0] got_q[$];
    logic [DATA_W:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] smp(input int idx);
        logic [15:0] v;
        v = idx[15:0];
        return {v, ~v};
    endfunction

    task automatic push_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) exp_q.push_back({(i == hi), smp(i)});
    endtask

    task automatic check_out(input string tag);
        int n;
        int mism;
        chk($sformatf("%s_count", tag), 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        if (exp_q.size() <= 64) begin
            for (int i = 0; i < n; i++) chk($sformatf("%s_out%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        end else begin
            mism = 0;
            for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) mism++;
            chk($sformatf("%s_mismatches", tag), 64'(mism), 64'd0);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic send(input int first, input int n, input bit last_flag, input int cp, input int len);
        for (int i = 0; i < n; i++) begin
            int guard;
            bit acc;
            i_tvalid = 1'b1;
            i_tdata  = smp(first + i);
            i_tlast  = last_flag && (i == n - 1);
            guard = 0;
            acc   = 1'b0;
            while (!acc && guard < 50) begin
                @(negedge clk);
                acc = i_tready;
                if (!acc && (((first + i) % len) < cp)) cp_stalls++;
                @(posedge clk);
                #1;
                guard++;
            end
            if (!acc) begin
                chk("accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    task automatic drain();
        repeat (10) @(posedge clk);
        #1;
    endtask

    // New sizes take effect at the symbol start that follows a clear.
    task automatic cfg(input int f, input int c);
        fft_size = CNT_W'(f);
        cp_size  = CNT_W'(c);
        clear    = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin : ready_driver
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                o_tready = (ph == 0);
                ph = (ph == 2) ? 0 : ph + 1;
            end else begin
                o_tready = 1'b1;
                ph = 0;
            end
        end
    end

    initial begin : monitor
        logic [DATA_W:0] prev_out;
        bit prev_stall;
        prev_stall = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (o_tvalid && o_tready) got_q.push_back({o_tlast, o_tdata});
                if (trunc_err) trunc_cnt++;
                if (prev_stall && (!o_tvalid || ({o_tlast, o_tdata} !== prev_out))) stall_viol++;
                prev_stall = o_tvalid && !o_tready;
                prev_out   = {o_tlast, o_tdata};
                if (i_tvalid && i_tready && (i_tdata == smp(2)) && acc_cyc < 0) acc_cyc = cyc;
                if (o_tvalid && (o_tdata == smp(2)) && out_cyc < 0) out_cyc = cyc;
            end
        end
    end

    initial begin
        reset    = 1'b1;
        clear    = 1'b0;
        fft_size = 16'd8;
        cp_size  = 16'd2;
        i_tdata  = '0;
        i_tlast  = 1'b0;
        i_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid", 64'(o_tvalid), 64'd0);
        chk("rst_tlast", 64'(o_tlast), 64'd0);
        chk("rst_tdata", 64'(o_tdata), 64'd0);
        chk("rst_trunc", 64'(trunc_err), 64'd0);
        chk("rst_symcount", 64'(sym_count), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Nominal: 8 + 2 CP, two symbols in one packet
        trunc_cnt = 0;
        send(0, 20, 1'b1, 2, 10);
        drain();
        push_range(2, 9);
        push_range(12, 19);
        check_out("nominal");
        chk("nominal_symcount", 64'(sym_count), 64'd2);
        chk("nominal_trunc", 64'(trunc_cnt), 64'd0);
        chk("nominal_latency", 64'(out_cyc), 64'(acc_cyc + 1));

        // Back-pressure 1-on/2-off
        stall_viol = 0;
        cp_stalls  = 0;
        bp_mode    = 1'b1;
        send(0, 20, 1'b1, 2, 10);
        drain();
        bp_mode = 1'b0;
        drain();
        push_range(2, 9);
        push_range(12, 19);
        check_out("bp");
        chk("bp_stable", 64'(stall_viol), 64'd0);
        chk("bp_cp_full_rate", 64'(cp_stalls), 64'd0);
        chk("bp_symcount", 64'(sym_count), 64'd4);

        // Zero CP, fft 4
        cfg(4, 0);
        send(0, 8, 1'b1, 0, 1);
        drain();
        push_range(0, 3);
        push_range(4, 7);
        check_out("zero_cp");
        chk("zero_cp_symcount", 64'(sym_count), 64'd6);

        // Default frame 1024 + 128
        cfg(1024, 128);
        send(0, 2304, 1'b1, 0, 1);
        drain();
        push_range(128, 1151);
        push_range(1152 + 128, 2303);
        check_out("frame1024");
        chk("frame1024_symcount", 64'(sym_count), 64'd8);

        // Truncation inside data phase, then a normal packet
        cfg(8, 2);
        trunc_cnt = 0;
        send(0, 7, 1'b1, 0, 1);
        drain();
        push_range(2, 6);
        check_out("trunc_data");
        chk("trunc_data_pulses", 64'(trunc_cnt), 64'd1);
        chk("trunc_data_symcount", 64'(sym_count), 64'd8);
        send(0, 20, 1'b1, 0, 1);
        drain();
        push_range(2, 9);
        push_range(12, 19);
        check_out("after_trunc");
        chk("after_trunc_symcount", 64'(sym_count), 64'd10);

        // Truncation inside the prefix
        trunc_cnt = 0;
        send(0, 2, 1'b1, 0, 1);
        drain();
        check_out("trunc_cp");
        chk("trunc_cp_pulses", 64'(trunc_cnt), 64'd1);
        chk("trunc_cp_symcount", 64'(sym_count), 64'd10);

        // CP 2 -> 4 during symbol 0 data phase
        send(0, 5, 1'b0, 0, 1);
        cp_size = 16'd4;
        send(5, 17, 1'b1, 0, 1);
        drain();
        push_range(2, 9);
        push_range(14, 21);
        check_out("cfg_change");
        chk("cfg_change_symcount", 64'(sym_count), 64'd12);

        // Asynchronous reset mid data phase
        cfg(8, 2);
        send(0, 5, 1'b0, 0, 1);
        chk("pre_reset_tvalid", 64'(o_tvalid), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_tvalid", 64'(o_tvalid), 64'd0);
        chk("async_rst_tdata", 64'(o_tdata), 64'd0);
        chk("async_rst_tlast", 64'(o_tlast), 64'd0);
        chk("async_rst_symcount", 64'(sym_count), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        got_q.delete();
        send(0, 20, 1'b1, 0, 1);
        drain();
        push_range(2, 9);
        push_range(12, 19);
        check_out("post_reset");
        chk("post_reset_symcount", 64'(sym_count), 64'd2);

        // Synchronous clear mid data phase
        send(0, 5, 1'b0, 0, 1);
        i_tvalid = 1'b1;
        i_tdata  = smp(99);
        clear    = 1'b1;
        #1;
        chk("clear_tready", 64'(i_tready), 64'd0);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        i_tvalid = 1'b0;
        chk("clear_tvalid", 64'(o_tvalid), 64'd0);
        chk("clear_symcount", 64'(sym_count), 64'd2);
        got_q.delete();
        send(0, 20, 1'b1, 0, 1);
        drain();
        push_range(2, 9);
        push_range(12, 19);
        check_out("post_clear");
        chk("post_clear_symcount", 64'(sym_count), 64'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
